// File: rtl/elevator_call_dispatcher_if.sv
// elevator_call_dispatcher_if: call/tick inputs and car status outputs of the dispatcher
interface elevator_call_dispatcher_if;
  logic [7:0] call_btn;
  logic       tick;
  logic [2:0] cur_floor;
  logic [7:0] floor_onehot;
  logic [7:0] pending;
  logic       dir_up;
  logic       dir_down;
  logic       door_open;
  logic       arrive;
  logic       busy;
  modport master (
    output call_btn, tick,
    input  cur_floor, floor_onehot, pending, dir_up, dir_down, door_open, arrive, busy
  );
  modport slave (
    input  call_btn, tick,
    output cur_floor, floor_onehot, pending, dir_up, dir_down, door_open, arrive, busy
  );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher: single-car 8-floor dispatcher with request latching and door timing
module elevator_call_dispatcher #(
  parameter logic [2:0] START_FLOOR = 3'd0,
  parameter logic [3:0] DOOR_TICKS  = 4'd4
) (
  input logic clk,
  input logic rst,
  elevator_call_dispatcher_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
  state_t     state;
  logic [2:0] floor;
  logic [7:0] pend;
  logic [3:0] cnt;
  logic       pref;
  logic       arr;
  logic [7:0] here, above, below, req, pend_set;
  logic       stopped;
  always_comb begin
    here     = 8'd1 << floor;
    above    = ~((here << 1) - 8'd1);
    below    = here - 8'd1;
    req      = pend | bus.call_btn;
    stopped  = (state == IDLE) || (state == DOOR_OPEN);
    // a call for the floor the car is standing at is answered directly, never queued
    pend_set = pend | (bus.call_btn & ~(stopped ? here : 8'h00));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      floor <= START_FLOOR;
      pend  <= 8'h00;
      cnt   <= 4'd0;
      pref  <= 1'b1;
      arr   <= 1'b0;
    end else begin
      arr  <= 1'b0;
      pend <= pend_set;
      case (state)
        IDLE: begin
          if (|(req & here)) begin
            state <= DOOR_OPEN;
            cnt   <= DOOR_TICKS;
            arr   <= 1'b1;
            pend  <= pend_set & ~here;
          end else if (|(req & above) && (!(|(req & below)) || pref)) begin
            state <= MOVE_UP;
            pref  <= 1'b1;
          end else if (|(req & below)) begin
            state <= MOVE_DOWN;
            pref  <= 1'b0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (|(pend & here)) begin
            state <= DOOR_OPEN;
            cnt   <= DOOR_TICKS;
            arr   <= 1'b1;
            pend  <= pend_set & ~here;
          end else if (!(|(pend & (state == MOVE_UP ? above : below)))) begin
            state <= IDLE;
          end else if (bus.tick) begin
            floor <= state == MOVE_UP ? (floor == 3'd7 ? floor : floor + 3'd1)
                                      : (floor == 3'd0 ? floor : floor - 3'd1);
          end
        end
        default: begin
          if (|(bus.call_btn & here)) begin
            cnt <= DOOR_TICKS;
          end else if (bus.tick) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= IDLE;
          end
        end
      endcase
    end
  end
  assign bus.cur_floor    = floor;
  assign bus.floor_onehot = 8'd1 << floor;
  assign bus.pending      = pend;
  assign bus.dir_up       = state == MOVE_UP;
  assign bus.dir_down     = state == MOVE_DOWN;
  assign bus.door_open    = state == DOOR_OPEN;
  assign bus.arrive       = arr;
  assign bus.busy         = (state != IDLE) || (pend != 8'h00);
endmodule

// File: doc/elevator_call_dispatcher.md
ELEVATOR_CALL_DISPATCHER -- requirements
Module: elevator_call_dispatcher

Interface
REQ-001 Parameter: START_FLOOR, default 0, floor index loaded into cur_floor on reset (0-7).
REQ-002 Parameter: DOOR_TICKS, default 4, number of tick pulses the door stays open (1-15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 call_btn  input  8  floor call buttons; bit f requests floor f; level or pulse, sampled every cycle.
REQ-006 tick  input  1  one-cycle movement/door strobe from an external divider; the car moves at most one floor per tick.
REQ-007 cur_floor  output  3  binary index of the current floor.
REQ-008 floor_onehot  output  8  one-hot decode of cur_floor.
REQ-009 pending  output  8  latched, unserved floor requests.
REQ-010 dir_up / dir_down  output  1 each  high while the state is MOVE_UP / MOVE_DOWN.
REQ-011 door_open  output  1  high while the state is DOOR_OPEN.
REQ-012 arrive  output  1  one-cycle pulse in the first DOOR_OPEN cycle of each stop.
REQ-013 busy  output  1  high when the state is not IDLE or pending is non-zero.

Function
REQ-014 The states SHALL be IDLE, MOVE_UP, MOVE_DOWN and DOOR_OPEN; all outputs SHALL be registered or decoded from registered state only.
REQ-015 The next value of pending SHALL be pending OR call_btn, minus any bit cleared this cycle.
- Exception: call_btn[cur_floor] is never latched while in IDLE or DOOR_OPEN.
REQ-016 IDLE, in priority order:
- call_btn[cur_floor] or pending[cur_floor] -> DOOR_OPEN.
- Requests only above cur_floor -> MOVE_UP.
- Requests only below -> MOVE_DOWN.
- Requests both above and below -> direction given by dir_pref.
- No requests -> stay in IDLE.
REQ-017 dir_pref SHALL be set to 1 on entry to MOVE_UP and cleared to 0 on entry to MOVE_DOWN; its reset value is 1 (up).
REQ-018 MOVE_UP/MOVE_DOWN, evaluated every cycle in priority order:
- pending[cur_floor] set -> DOOR_OPEN, clear that bit, no floor change even when tick=1.
- No pending bit strictly beyond cur_floor in the travel direction -> IDLE.
- tick=1 -> cur_floor +1 (MOVE_UP) or -1 (MOVE_DOWN).
- Otherwise hold.
REQ-019 cur_floor SHALL saturate at 7 and 0 and never wrap, even if a tick arrives at the end floor.
REQ-020 On entry to DOOR_OPEN, a 4-bit door counter SHALL load DOOR_TICKS and arrive SHALL pulse for exactly one cycle.
REQ-021 In DOOR_OPEN, each tick SHALL decrement the counter; a tick with counter==1 SHALL move the state to IDLE.
REQ-022 In DOOR_OPEN, call_btn[cur_floor] SHALL reload the counter to DOOR_TICKS (door extension); it SHALL NOT re-pulse arrive, even when it coincides with the final tick.
REQ-023 With tick=0 held, cur_floor and the door counter SHALL stay frozen; request latching and IDLE decisions SHALL continue.
REQ-024 A call for a floor between cur_floor and the current target, in the travel direction, SHALL be served on the way (stop at first pending floor reached).

Reset
REQ-025 While rst=1, on each clock edge:
- State -> IDLE, cur_floor=START_FLOOR, pending=0, door counter=0, dir_pref=1.
- door_open, arrive, dir_up, dir_down and busy all 0.
- rst has priority over call_btn and tick.
REQ-026 Reset asserted mid-move or with the door open SHALL abandon all requests; the first post-reset cycle is IDLE at START_FLOOR.

Verification
REQ-027 Basic trip: floor 0, tick=1 continuous, call_btn=8'h08 for one cycle -> pending=8'h08 next cycle; MOVE_UP; cur_floor 1,2,3 on consecutive cycles; next cycle door_open=1 with arrive=1 for one cycle and pending=0; door_open held exactly 4 cycles; then IDLE with busy=0.
REQ-028 Door extension: in DOOR_OPEN at floor 3, call_btn[3] pulsed on the cycle of the third tick -> door_open lasts 4 more ticks from that point; arrive stays 0; pending stays 0.
REQ-029 On-the-way stop: from floor 0, call floor 6; when cur_floor=1, call floor 2 -> car stops at 2 (arrive), then resumes MOVE_UP and stops at 6; pending reaches 0.
REQ-030 Tie-break: idle at floor 4 with dir_pref=1, call_btn=8'h44 in one cycle -> MOVE_UP, serve 6 first, then MOVE_DOWN to 2.
REQ-031 Stall and reset: tick=0 during MOVE_DOWN -> cur_floor constant for 10 cycles; then rst=1 for one cycle -> cur_floor=0, pending=0, IDLE, all status outputs 0.
